// File: rtl/mult_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult_pkg : shared types and constants for the 8x8 multiplier consumers
// Revision : 1.0
// ---------------------------------------------------------------------------
package mult_pkg;

  localparam int MULT_LAT_DEF = 4;
  localparam int PROD_W       = 16;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/valid_delay.sv
`default_nettype none
// ---------------------------------------------------------------------------
// valid_delay : DEPTH-stage 1-bit shift register, output is the tail stage
// Revision    : 1.0
// ---------------------------------------------------------------------------
module valid_delay #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic tail
);

  logic [DEPTH-1:0] shift_q;
  logic [DEPTH-1:0] shift_d;

  generate
    if (DEPTH == 1) begin : g_single
      always_comb shift_d = din;
    end else begin : g_chain
      always_comb shift_d = {shift_q[DEPTH-2:0], din};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shift_q <= '0;
    else        shift_q <= shift_d;
  end

  assign tail = shift_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/mult_dot_acc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult_dot_acc : accumulates LEN multiplier products into one dot-product sum
// Revision     : 1.0
// ---------------------------------------------------------------------------
module mult_dot_acc
  import mult_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int LEN      = 4,
  parameter int ACC_W    = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] p_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic              busy
);

  localparam int                CNT_W  = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0]  LEN_C  = CNT_W'(LEN);
  localparam logic [CNT_W-1:0]  LEN_M1 = CNT_W'(LEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic             out_ovf_q, out_ovf_d;

  logic             issue;
  logic             tail;
  logic [ACC_W:0]   acc_sum;

  assign in_ready  = (state_q == ST_ISSUE);
  assign out_valid = (state_q == ST_DONE);
  assign issue     = in_valid & in_ready;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  // Products in flight are exactly the issues not yet accumulated.
  assign busy      = (state_q != ST_ISSUE) || (issue_cnt_q != acc_cnt_q);

  valid_delay #(
    .DEPTH (MULT_LAT)
  ) u_valid_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (issue),
    .tail  (tail)
  );

  assign acc_sum = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, p_in};

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    acc_cnt_d   = acc_cnt_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;

    if (tail) begin
      acc_d     = acc_sum[ACC_W-1:0];
      ovf_d     = ovf_q | acc_sum[ACC_W];
      acc_cnt_d = acc_cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_ISSUE: begin
        if (issue) begin
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
          if (issue_cnt_q == LEN_M1) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Capture the result including the product landing on this edge.
        if (acc_cnt_d == LEN_C) begin
          state_d   = ST_DONE;
          out_sum_d = acc_d;
          out_ovf_d = ovf_d;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_ISSUE;
          issue_cnt_d = '0;
          acc_cnt_d   = '0;
          acc_d       = '0;
          ovf_d       = 1'b0;
        end
      end
      default: state_d = ST_ISSUE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ISSUE;
      issue_cnt_q <= '0;
      acc_cnt_q   <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

`ifndef SYNTHESIS
  // Issue is blocked outside ISSUE, so no product may land while a result waits.
  a_no_product_in_done: assert property (
    @(posedge clk) disable iff (!rst_n) !((state_q == ST_DONE) && tail)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_dot_acc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mult_dot_acc : directed self-checking bench with a behavioural multiplier
// Revision        : 1.0
// ---------------------------------------------------------------------------
module tb_mult_dot_acc;

  localparam int LAT = 4;
  localparam int BOUND = 60;

  logic        clk;
  logic        rst_n;
  logic [7:0]  a, b;
  logic [15:0] mp [LAT];
  logic [15:0] p_in;
  logic [2:0]  in_valid, in_ready, out_valid, out_ready, busy, out_ovf;
  logic [17:0] sum_a;
  logic [16:0] sum_o;
  logic [17:0] sum_l;
  int          cyc;
  int          pass_cnt;
  int          chk_cnt;

  // index 0: defaults, 1: ACC_W=17, 2: LEN=1
  mult_dot_acc #(.MULT_LAT(LAT), .LEN(4), .ACC_W(18)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .p_in(p_in), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_sum(sum_a), .out_ovf(out_ovf[0]), .busy(busy[0]));

  mult_dot_acc #(.MULT_LAT(LAT), .LEN(4), .ACC_W(17)) u_ovf (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .p_in(p_in), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_sum(sum_o), .out_ovf(out_ovf[1]), .busy(busy[1]));

  mult_dot_acc #(.MULT_LAT(LAT), .LEN(1), .ACC_W(18)) u_len1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .p_in(p_in), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_sum(sum_l), .out_ovf(out_ovf[2]), .busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: operands sampled at edge k appear on p_in for edge k+LAT.
  initial for (int i = 0; i < LAT; i++) mp[i] = 16'd0;
  always @(posedge clk) begin
    mp[0] <= 16'(a) * 16'(b);
    for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
  end
  assign p_in = mp[LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [7:0] xa, input logic [7:0] xb,
                      output int edge_no);
    int n;
    n = 0;
    a = xa;
    b = xb;
    in_valid[k] = 1'b1;
    while (!in_ready[k] && n < BOUND) begin
      tick();
      n++;
    end
    if (n >= BOUND) begin
      chk_cnt++;
      $display("FAIL send_timeout dut=%0d in_ready stayed %0b, required 1", k, in_ready[k]);
    end
    tick();
    edge_no = cyc;
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_valid(input int k, output int edge_no);
    int n;
    n = 0;
    while (!out_valid[k] && n < BOUND) begin
      tick();
      n++;
    end
    if (n >= BOUND) begin
      chk_cnt++;
      $display("FAIL wait_valid_timeout dut=%0d out_valid stayed %0b, required 1", k, out_valid[k]);
    end
    edge_no = cyc;
  endtask

  task automatic handshake(input int k);
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
  endtask

  task automatic test_reset();
    chk_cnt++; if (in_ready[0] !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready[0]); else pass_cnt++;
    chk_cnt++; if (out_valid[0] !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid[0]); else pass_cnt++;
    chk_cnt++; if (sum_a !== 18'd0) $display("FAIL reset_out_sum got %0d want 0", sum_a); else pass_cnt++;
    chk_cnt++; if (out_ovf[0] !== 1'b0) $display("FAIL reset_out_ovf got %0b want 0", out_ovf[0]); else pass_cnt++;
    chk_cnt++; if (busy[0] !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy[0]); else pass_cnt++;
  endtask

  task automatic test_basic();
    int t0, t, tv;
    send(0, 8'd127, 8'd127, t0);
    send(0, 8'd255, 8'd255, t);
    send(0, 8'd76,  8'd106, t);
    send(0, 8'd120, 8'd55,  t);
    wait_valid(0, tv);
    chk_cnt++; if (tv - t0 !== 7) $display("FAIL basic_latency got %0d want 7", tv - t0); else pass_cnt++;
    chk_cnt++; if (sum_a !== 18'd95810) $display("FAIL basic_sum got %0d want 95810", sum_a); else pass_cnt++;
    chk_cnt++; if (out_ovf[0] !== 1'b0) $display("FAIL basic_ovf got %0b want 0", out_ovf[0]); else pass_cnt++;
    chk_cnt++; if (in_ready[0] !== 1'b0) $display("FAIL basic_in_ready_done got %0b want 0", in_ready[0]); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    a = 8'd9;
    b = 8'd9;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_cnt++; if (sum_a !== 18'd95810) $display("FAIL bp_sum_hold cyc=%0d got %0d want 95810", i, sum_a); else pass_cnt++;
      chk_cnt++; if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1)
        $display("FAIL bp_flags cyc=%0d in_ready=%0b out_valid=%0b want 0/1", i, in_ready[0], out_valid[0]);
      else pass_cnt++;
    end
    in_valid[0] = 1'b0;
    handshake(0);
    chk_cnt++; if (out_valid[0] !== 1'b0) $display("FAIL bp_release_valid got %0b want 0", out_valid[0]); else pass_cnt++;
    chk_cnt++; if (in_ready[0] !== 1'b1) $display("FAIL bp_release_ready got %0b want 1", in_ready[0]); else pass_cnt++;
    chk_cnt++; if (busy[0] !== 1'b0) $display("FAIL bp_release_busy got %0b want 0", busy[0]); else pass_cnt++;
  endtask

  task automatic test_gapped();
    logic [7:0] va [4];
    logic [7:0] vb [4];
    int t, tv;
    va = '{8'd127, 8'd255, 8'd76, 8'd120};
    vb = '{8'd127, 8'd255, 8'd106, 8'd55};
    for (int i = 0; i < 4; i++) begin
      send(0, va[i], vb[i], t);
      if (i < 3) begin
        tick();
        tick();
      end
    end
    wait_valid(0, tv);
    chk_cnt++; if (tv - t !== LAT) $display("FAIL gapped_latency got %0d want %0d", tv - t, LAT); else pass_cnt++;
    chk_cnt++; if (sum_a !== 18'd95810) $display("FAIL gapped_sum got %0d want 95810", sum_a); else pass_cnt++;
    handshake(0);
  endtask

  // Issue every 4th cycle so each later issue coincides with an accumulate.
  task automatic test_simultaneous();
    int t, tv;
    for (int i = 0; i < 4; i++) begin
      send(0, 8'(2*i + 1), 8'(2*i + 2), t);
      if (i < 3) for (int j = 0; j < 3; j++) tick();
    end
    wait_valid(0, tv);
    chk_cnt++; if (tv - t !== LAT) $display("FAIL simul_latency got %0d want %0d", tv - t, LAT); else pass_cnt++;
    chk_cnt++; if (sum_a !== 18'd100) $display("FAIL simul_sum got %0d want 100", sum_a); else pass_cnt++;
    handshake(0);
  endtask

  task automatic test_back_to_back();
    int t0, t1, t, tv;
    out_ready[0] = 1'b1;
    send(0, 8'd1, 8'd1, t0);
    for (int i = 0; i < 3; i++) send(0, 8'd1, 8'd1, t);
    wait_valid(0, tv);
    chk_cnt++; if (sum_a !== 18'd4) $display("FAIL b2b_sum0 got %0d want 4", sum_a); else pass_cnt++;
    send(0, 8'd2, 8'd2, t1);
    for (int i = 0; i < 3; i++) send(0, 8'd2, 8'd2, t);
    chk_cnt++; if (t1 - t0 !== 9) $display("FAIL b2b_period got %0d want 9", t1 - t0); else pass_cnt++;
    wait_valid(0, tv);
    chk_cnt++; if (sum_a !== 18'd16) $display("FAIL b2b_sum1 got %0d want 16", sum_a); else pass_cnt++;
    tick();
    out_ready[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int t, tv;
    send(0, 8'd200, 8'd200, t);
    send(0, 8'd200, 8'd200, t);
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (sum_a !== 18'd0) $display("FAIL rstmid_sum got %0d want 0", sum_a); else pass_cnt++;
    chk_cnt++; if (busy[0] !== 1'b0 || out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1)
      $display("FAIL rstmid_flags busy=%0b out_valid=%0b in_ready=%0b want 0/0/1", busy[0], out_valid[0], in_ready[0]);
    else pass_cnt++;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(0, 8'd2, 8'd3, t);
    wait_valid(0, tv);
    chk_cnt++; if (sum_a !== 18'd24) $display("FAIL rstmid_new_sum got %0d want 24", sum_a); else pass_cnt++;
    handshake(0);
  endtask

  task automatic test_overflow();
    int t, tv;
    for (int i = 0; i < 4; i++) send(1, 8'd255, 8'd255, t);
    wait_valid(1, tv);
    chk_cnt++; if (sum_o !== 17'd129028) $display("FAIL ovf_sum got %0d want 129028", sum_o); else pass_cnt++;
    chk_cnt++; if (out_ovf[1] !== 1'b1) $display("FAIL ovf_flag got %0b want 1", out_ovf[1]); else pass_cnt++;
    handshake(1);
    for (int i = 0; i < 4; i++) send(1, 8'd1, 8'd1, t);
    wait_valid(1, tv);
    chk_cnt++; if (sum_o !== 17'd4) $display("FAIL ovf_next_sum got %0d want 4", sum_o); else pass_cnt++;
    chk_cnt++; if (out_ovf[1] !== 1'b0) $display("FAIL ovf_next_flag got %0b want 0", out_ovf[1]); else pass_cnt++;
    handshake(1);
  endtask

  task automatic test_len1();
    logic [7:0]  va [2];
    logic [7:0]  vb [2];
    logic [17:0] exp [2];
    int t, tv;
    va  = '{8'd10, 8'd3};
    vb  = '{8'd10, 8'd7};
    exp = '{18'd100, 18'd21};
    out_ready[2] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send(2, va[i], vb[i], t);
      chk_cnt++; if (in_ready[2] !== 1'b0) $display("FAIL len1_ready_after_issue v=%0d got %0b want 0", i, in_ready[2]); else pass_cnt++;
      wait_valid(2, tv);
      chk_cnt++; if (tv - t !== LAT) $display("FAIL len1_latency v=%0d got %0d want %0d", i, tv - t, LAT); else pass_cnt++;
      chk_cnt++; if (sum_l !== exp[i]) $display("FAIL len1_sum v=%0d got %0d want %0d", i, sum_l, exp[i]); else pass_cnt++;
      tick();
      chk_cnt++; if (in_ready[2] !== 1'b1 || out_valid[2] !== 1'b0)
        $display("FAIL len1_after_hs v=%0d in_ready=%0b out_valid=%0b want 1/0", i, in_ready[2], out_valid[2]);
      else pass_cnt++;
    end
    out_ready[2] = 1'b0;
  endtask

  initial begin
    pass_cnt  = 0;
    chk_cnt   = 0;
    rst_n     = 1'b0;
    a         = 8'd0;
    b         = 8'd0;
    in_valid  = 3'b000;
    out_ready = 3'b000;
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_basic();
    test_backpressure();
    test_gapped();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_overflow();
    test_len1();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_dot_acc.md
Name: mult_dot_acc

Overview:
- Downstream consumer of the 8x8 pipelined multiplier (mult_p).
- Tracks the validity of operands issued into the multiplier and accumulates LEN products into one dot-product sum.
- Presents each sum on a valid/ready output port.
- Issue-side flow control (in_ready) guarantees no product is lost while a result is waiting to be taken.

Parameters:
- MULT_LAT, 4: edges between an operand issue and the edge at which that product is sampled on p_in.
- LEN, 4: products per vector (>=1).
- ACC_W, 18: accumulator/result width (>=16).

Ports:
- clk  in  1  rising-edge clock, shared with the multiplier.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream presents A/B to the multiplier this cycle.
- in_ready  out  1  block accepts an issue; issue = in_valid & in_ready.
- p_in  in  16  product from the multiplier.
- out_valid  out  1  out_sum/out_ovf are valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  ACC_W  dot-product sum, modulo 2^ACC_W.
- out_ovf  out  1  sticky: carry out of ACC_W occurred during this vector.
- busy  out  1  state != ISSUE, or any product is in flight.

Behaviour:
- Reset (async, rst_n=0): state=ISSUE, issue_cnt=0, acc_cnt=0, acc=0, ovf=0, valid delay line cleared. Outputs: in_ready=1, out_valid=0, out_sum=0, out_ovf=0, busy=0. Reset mid-vector discards all in-flight products.
- Valid delay line: MULT_LAT-deep shift of issue. An issue sampled at edge k makes the line's tail high in the cycle before edge k+MULT_LAT; p_in is added at edge k+MULT_LAT. p_in is ignored when the tail is low.
- Accumulate: {ovf_carry, acc} = acc + zero-extended p_in. Result wraps modulo 2^ACC_W; ovf |= carry. acc_cnt increments on each accumulate.
- State ISSUE: in_ready=1. Each issue increments issue_cnt. An issue that makes issue_cnt==LEN moves to WAIT at that edge.
- State WAIT: in_ready=0. The tail keeps accumulating. The edge at which acc_cnt reaches LEN moves to DONE; out_sum/out_ovf are loaded with the final value, including the last product.
- State DONE: out_valid=1, in_ready=0. out_sum and out_ovf are held stable while out_ready=0.
- DONE exit: on out_valid & out_ready, go to ISSUE and clear acc, ovf, issue_cnt and acc_cnt. in_ready=1 from the next cycle.
- Latency: out_valid rises after edge (last issue edge)+MULT_LAT. With back-to-back issue from t0, that is edge t0+LEN-1+MULT_LAT.
- Throughput: one vector per LEN+MULT_LAT+1 cycles when out_ready is held high.
- Boundary, simultaneous accumulate and issue: allowed in ISSUE; the two counters are independent.
- Boundary, LEN=1: the first issue goes straight to WAIT.
- Boundary, out_ready high while out_valid is low: no effect.
- Boundary, products arriving in DONE: impossible by construction; this is an assertion target.
- Boundary, in_valid while in_ready=0: ignored; the upstream must hold its operands.

Decomposition:
- Shared package mult_pkg holds:
  - state enum ST_ISSUE/ST_WAIT/ST_DONE (2-bit);
  - default constants MULT_LAT_DEF=4 and PROD_W=16.
- Sub-module valid_delay (param DEPTH): shift register of width 1, async active-low clear, output = tail. It is reusable for other pipelined multipliers.

Test Plan:
- Basic vector: LEN=4, back-to-back issues of pairs (127,127),(255,255),(76,106),(120,55); products 16129, 65025, 8056, 6600 -> out_valid 7 edges after the first issue, out_sum=95810, out_ovf=0.
- Backpressure: hold out_ready=0 for 10 cycles after the basic vector -> out_sum stays 95810, in_ready stays 0, no issue accepted. Release -> in_ready=1 the next cycle and the next vector starts from acc=0.
- Gapped issue: the same 4 pairs with 2 idle cycles between each -> out_sum=95810. out_valid rises MULT_LAT edges after the 4th issue.
- Overflow: ACC_W=17, four issues of (255,255) -> out_sum=129028 (260100 mod 131072), out_ovf=1. The next vector of (1,1)x4 -> out_sum=4, out_ovf=0.
- Reset mid-operation: assert rst_n=0 after 2 issues -> all outputs are zero immediately. After release, a new (2,3)x4 vector -> out_sum=24; no stale products are included.
- LEN=1 with streaming out_ready=1: issues (10,10) and (3,7) -> out_sum=100, then out_sum=21. in_ready is low from each issue until the cycle after its handshake.
